// File: rtl/result_axis_tx.sv
// AXI4-Stream transmit path for 3x3 result matrices: small FIFO plus a registered
// output stage with TLAST framing, backpressure and sticky overflow reporting.
module result_axis_tx #(
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_LEN  = 4,
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_res_valid,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  output logic                  o_res_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic [CW-1:0]         o_fifo_count,
  output logic                  o_overflow,
  input  logic                  i_clr_overflow,
  output logic                  o_frame_done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  localparam logic [0:0] OUT_EMPTY  = 1'b0;
  localparam logic [0:0] OUT_LOADED = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d, mem_cnt;
  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_done_q, frame_done_d;
  logic                  wr, hs, load, mem_empty, mem_push, mem_pop;

  // Ready depends only on the registered count, never on m_axis_ready.
  assign o_res_ready = (count_q != FULL_CNT);
  assign wr          = i_res_valid && o_res_ready;
  assign hs          = m_axis_valid && m_axis_ready;
  assign load        = (state_q == OUT_EMPTY) || hs;
  // The output register holds one of the counted entries when loaded.
  assign mem_cnt     = count_q - CW'(state_q);
  assign mem_empty   = (mem_cnt == '0);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mem_push = wr;
    mem_pop  = 1'b0;
    if (load) begin
      if (!mem_empty) begin
        data_d  = mem_q[rd_ptr_q];
        mem_pop = 1'b1;
        state_d = OUT_LOADED;
      end else if (wr) begin
        // Bypass the memory so an idle path has one cycle of latency.
        data_d   = i_res_data;
        mem_push = 1'b0;
        state_d  = OUT_LOADED;
      end else begin
        state_d = OUT_EMPTY;
      end
    end
  end

  always_comb begin
    count_d      = count_q + CW'(wr) - CW'(hs);
    beat_d       = beat_q;
    if (hs) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    frame_done_d = hs && m_axis_last;
    // A blocked write sets the flag even when a clear arrives in the same cycle.
    overflow_d   = (i_res_valid && !o_res_ready) || (overflow_q && !i_clr_overflow);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= OUT_EMPTY;
      data_q       <= '0;
      beat_q       <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (mem_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (mem_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q      <= count_d;
      state_q      <= state_d;
      data_q       <= data_d;
      beat_q       <= beat_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_push) mem_q[wr_ptr_q] <= i_res_data;
  end

  assign m_axis_valid = (state_q == OUT_LOADED);
  assign m_axis_data  = data_q;
  assign m_axis_last  = m_axis_valid && (beat_q == LAST_BEAT);
  assign o_fifo_count = count_q;
  assign o_overflow   = overflow_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_result_axis_tx.sv
// Directed self-checking bench for result_axis_tx (defaults: 144-bit, depth 4, frame 4).
module tb_result_axis_tx;

  localparam int unsigned DW = 144;
  localparam int unsigned CW = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_res_valid = 1'b0;
  logic [DW-1:0] i_res_data = '0;
  logic          o_res_ready;
  logic          m_axis_valid;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_last;
  logic          m_axis_ready = 1'b0;
  logic [CW-1:0] o_fifo_count;
  logic          o_overflow;
  logic          i_clr_overflow = 1'b0;
  logic          o_frame_done;

  int n_vec = 0;
  int n_err = 0;

  result_axis_tx dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_res_valid    (i_res_valid),
    .i_res_data     (i_res_data),
    .o_res_ready    (o_res_ready),
    .m_axis_valid   (m_axis_valid),
    .m_axis_data    (m_axis_data),
    .m_axis_last    (m_axis_last),
    .m_axis_ready   (m_axis_ready),
    .o_fifo_count   (o_fifo_count),
    .o_overflow     (o_overflow),
    .i_clr_overflow (i_clr_overflow),
    .o_frame_done   (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n        = 1'b0;
    i_res_valid    = 1'b0;
    i_res_data     = '0;
    m_axis_ready   = 1'b0;
    i_clr_overflow = 1'b0;
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    i_res_valid = 1'b1;
    i_res_data  = d;
    tick();
    i_res_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] mk(input int v);
    logic [15:0] e;
    e = 16'(v);
    return {9{e}};
  endfunction

  logic [DW-1:0] exp_q [4];
  int n;

  initial begin
    #1;
    // Reset values while held in reset
    tick();
    check_eq("rst_valid", DW'(m_axis_valid), '0);
    check_eq("rst_last", DW'(m_axis_last), '0);
    check_eq("rst_data", m_axis_data, '0);
    check_eq("rst_count", DW'(o_fifo_count), '0);
    check_eq("rst_ovf", DW'(o_overflow), '0);
    check_eq("rst_done", DW'(o_frame_done), '0);
    check_eq("rst_ready", DW'(o_res_ready), DW'(1));

    // Single beat, one-cycle latency
    do_reset();
    m_axis_ready = 1'b1;
    push(DW'(1));
    check_eq("t1_valid", DW'(m_axis_valid), DW'(1));
    check_eq("t1_data", m_axis_data, DW'(1));
    check_eq("t1_last", DW'(m_axis_last), '0);
    check_eq("t1_count1", DW'(o_fifo_count), DW'(1));
    tick();
    check_eq("t1_count0", DW'(o_fifo_count), '0);
    check_eq("t1_valid0", DW'(m_axis_valid), '0);

    // Eight streamed beats, TLAST on beats 3 and 7
    do_reset();
    m_axis_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_res_valid = 1'b1;
      i_res_data  = mk(100 + i);
      tick();
      check_eq($sformatf("t2_data%0d", i), m_axis_data, mk(100 + i));
      check_eq($sformatf("t2_last%0d", i), DW'(m_axis_last), DW'(i % 4 == 3));
      check_eq($sformatf("t2_done%0d", i), DW'(o_frame_done), DW'(i == 4));
    end
    i_res_valid = 1'b0;
    tick();
    check_eq("t2_done_end", DW'(o_frame_done), DW'(1));
    check_eq("t2_valid_end", DW'(m_axis_valid), '0);
    tick();
    check_eq("t2_done_clr", DW'(o_frame_done), '0);

    // Fill, overflow, drain, clear
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q[i] = mk(16'hA0 + i);
      push(exp_q[i]);
    end
    check_eq("t3_count4", DW'(o_fifo_count), DW'(4));
    check_eq("t3_rdy0", DW'(o_res_ready), '0);
    check_eq("t3_ovf0", DW'(o_overflow), '0);
    push(DW'(16'hDEAD));
    check_eq("t3_ovf1", DW'(o_overflow), DW'(1));
    check_eq("t3_count_hold", DW'(o_fifo_count), DW'(4));
    m_axis_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_v%0d", i), DW'(m_axis_valid), DW'(1));
      check_eq($sformatf("t3_d%0d", i), m_axis_data, exp_q[i]);
      check_eq($sformatf("t3_l%0d", i), DW'(m_axis_last), DW'(i == 3));
      tick();
    end
    check_eq("t3_empty", DW'(m_axis_valid), '0);
    check_eq("t3_count0", DW'(o_fifo_count), '0);
    check_eq("t3_ovf_sticky", DW'(o_overflow), DW'(1));
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;
    check_eq("t3_ovf_clr", DW'(o_overflow), '0);

    // Backpressure pattern 1,0,0,1 while draining a frame
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q[i] = mk(16'hB0 + i);
      push(exp_q[i]);
    end
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      m_axis_ready = (c % 4 == 0) || (c % 4 == 3);
      check_eq($sformatf("t4_v%0d", c), DW'(m_axis_valid), DW'(1));
      check_eq($sformatf("t4_d%0d", c), m_axis_data, exp_q[n]);
      check_eq($sformatf("t4_l%0d", c), DW'(m_axis_last), DW'(n == 3));
      if (m_axis_ready) n++;
      tick();
    end
    check_eq("t4_beats", DW'(n), DW'(4));
    check_eq("t4_empty", DW'(m_axis_valid), '0);

    // Full FIFO: write blocked during a handshake
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q[i] = mk(16'hC0 + i);
      push(exp_q[i]);
    end
    m_axis_ready = 1'b1;
    push(DW'(16'hBEEF));
    check_eq("t5_count3", DW'(o_fifo_count), DW'(3));
    check_eq("t5_ovf", DW'(o_overflow), DW'(1));
    for (int i = 1; i < 4; i++) begin
      check_eq($sformatf("t5_d%0d", i), m_axis_data, exp_q[i]);
      tick();
    end
    check_eq("t5_no_beef", DW'(m_axis_valid), '0);

    // Reset mid-frame after beat 2 with three entries queued
    do_reset();
    for (int i = 0; i < 3; i++) push(mk(16'hE0 + i));
    m_axis_ready = 1'b1;
    for (int i = 3; i < 6; i++) push(mk(16'hE0 + i));
    m_axis_ready = 1'b0;
    check_eq("t6_count3", DW'(o_fifo_count), DW'(3));
    check_eq("t6_last_pre", DW'(m_axis_last), DW'(1));
    i_rst_n = 1'b0;
    #1;
    check_eq("t6_valid", DW'(m_axis_valid), '0);
    check_eq("t6_last", DW'(m_axis_last), '0);
    check_eq("t6_data", m_axis_data, '0);
    check_eq("t6_count", DW'(o_fifo_count), '0);
    check_eq("t6_rdy", DW'(o_res_ready), DW'(1));
    tick();
    i_rst_n = 1'b1;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(mk(16'hF0 + i));
      check_eq($sformatf("t6_fd%0d", i), m_axis_data, mk(16'hF0 + i));
      check_eq($sformatf("t6_fl%0d", i), DW'(m_axis_last), DW'(i == 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/result_axis_tx.md
Name: result_axis_tx

Overview:
Transmit side of the systolic array's AXI DMA interface. It accepts 3x3 result matrices (9 x 16-bit = 144 bits) from the array core, buffers them in a small FIFO, and streams them to the DMA S2MM channel as an AXI4-Stream master with backpressure and TLAST framing. It is the counterpart of the 48-bit operand ingest path. It sits between the array result port and the wrapper's m_axis_* pins.

Parameters:
DATA_WIDTH, 144, width of one result beat (9 elements x 16 bits)
FIFO_DEPTH, 4, result FIFO entries; power of 2, >= 2
FRAME_LEN, 4, beats per DMA frame; TLAST is asserted on beat FRAME_LEN-1; must be >= 1

Ports:
i_clk  in  1  single system clock; all logic rising-edge
i_rst_n  in  1  asynchronous active-low reset
i_res_valid  in  1  array presents a result matrix this cycle
i_res_data  in  DATA_WIDTH  result matrix, element 0 in [15:0]
o_res_ready  out  1  FIFO can accept a write this cycle
m_axis_valid  out  1  AXIS TVALID
m_axis_data  out  DATA_WIDTH  AXIS TDATA
m_axis_last  out  1  AXIS TLAST
m_axis_ready  in  1  AXIS TREADY from DMA
o_fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held, including the output register
o_overflow  out  1  sticky: a result arrived while full and was dropped
i_clr_overflow  in  1  synchronous clear of o_overflow
o_frame_done  out  1  one-cycle pulse after the TLAST beat handshakes

Behaviour:
- Reset (async assert, sync release): FIFO empty, state OUT_EMPTY, beat counter 0. m_axis_valid=0, m_axis_last=0, m_axis_data=0, o_fifo_count=0, o_overflow=0, o_frame_done=0, o_res_ready=1.
- Write: occurs when i_res_valid && o_res_ready. o_res_ready = (o_fifo_count != FIFO_DEPTH). It is driven from registered state only and has no combinational path from m_axis_ready.
- A write while full is blocked even if a read happens in the same cycle. The data is dropped and o_overflow is set the next cycle.
- o_overflow stays set until i_clr_overflow. If set and clear occur in the same cycle, set wins.
- Output stage FSM:
  - OUT_EMPTY -> OUT_LOADED: taken when the FIFO memory or an incoming write has data. The data is loaded into the m_axis_data register. Latency is 1 cycle: a write at edge k gives m_axis_valid=1 after edge k.
  - OUT_LOADED -> OUT_LOADED: on handshake (valid && ready) with more data available. The next entry is loaded, giving back-to-back beats with one beat per cycle at full throughput.
  - OUT_LOADED -> OUT_EMPTY: on handshake with nothing to load.
  - OUT_LOADED, no handshake: m_axis_data and m_axis_last hold stable. m_axis_valid never drops without a handshake (AXIS rule).
- o_fifo_count: +1 on write, -1 on handshake, unchanged when both occur. Range 0..FIFO_DEPTH.
- Beat counter: range 0..FRAME_LEN-1. Increments on each handshake and wraps to 0 after the FRAME_LEN-1 handshake.
  - m_axis_last = m_axis_valid && (beat_cnt == FRAME_LEN-1).
  - FRAME_LEN=1: every beat is last.
- o_frame_done: registered; high for exactly the one cycle after the TLAST handshake.
- FIFO pointers wrap modulo FIFO_DEPTH. No data reordering or duplication is permitted.
- Reset mid-frame: all buffered data is discarded, the beat counter returns to 0, and the next beat after release is beat 0 of a new frame.
- Element ordering within the beat is passed through unchanged. No arithmetic is performed on the data.

Test Plan:
- Reset, then write 0x...0001 with m_axis_ready=1 -> m_axis_valid=1 the cycle after the write, data 0x...0001, last=0, o_fifo_count goes 1 then 0 after the handshake.
- FRAME_LEN=4: stream 8 results with ready held at 1 -> 8 consecutive beats in order; last=1 on beats 3 and 7; o_frame_done pulses twice, each the cycle after beat 3 and beat 7.
- Hold m_axis_ready=0 and write 4 results -> o_fifo_count=4 and o_res_ready=0. A 5th write (0xDEAD) is dropped and o_overflow=1. Release ready -> exactly the 4 original values appear; i_clr_overflow then clears o_overflow.
- Backpressure: toggle m_axis_ready 1,0,0,1 mid-frame -> TDATA and TLAST stay stable while valid && !ready; no beat is lost or duplicated; TLAST position is unchanged.
- Full FIFO with simultaneous handshake and i_res_valid -> the write is blocked (count 4 -> 3) and o_overflow=1.
- Assert i_rst_n=0 after beat 2 of a frame with 3 entries queued -> outputs go to reset values immediately. After release, the next 4 writes form a fresh frame with last on the 4th beat.
